// File: rtl/conv_mac.sv
// conv_mac: 5x5 window multiply-accumulate with round, shift and saturate, AXI-Stream in and out.
// Optional macro CONV_MAC_SKID_EN adds a 2-entry skid buffer ahead of S1 (registered s_tready_o, latency 4).
module conv_mac #(
   parameter int PIXEL_W = 8,
   parameter int COEF_W  = 8,
   parameter int SHIFT   = 4
) (
   input  logic                   clk,
   input  logic                   arst_n,
   input  logic                   s_tvalid_i,
   input  logic [25*PIXEL_W-1:0]  s_tdata_i,
   input  logic                   s_tuser_i,
   input  logic                   s_tlast_i,
   output logic                   s_tready_o,
   output logic                   m_tvalid_o,
   output logic [PIXEL_W-1:0]     m_tdata_o,
   output logic                   m_tuser_o,
   output logic                   m_tlast_o,
   input  logic                   m_tready_i,
   input  logic                   coef_wr_i,
   input  logic [4:0]             coef_addr_i,
   input  logic [COEF_W-1:0]      coef_data_i,
   input  logic                   coef_commit_i,
   output logic                   coef_pending_o
);
   localparam int N  = 25;
   localparam int PW = PIXEL_W + COEF_W + 1;
   localparam int RW = PW + 3;
   localparam int SW = PIXEL_W + COEF_W + 6;
   localparam int DW = N * PIXEL_W;
   localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(1 << SHIFT);
   localparam logic signed [SW-1:0]     RND   = SW'((1 << SHIFT) >> 1);
   localparam logic signed [SW-1:0]     PMAX  = SW'((1 << PIXEL_W) - 1);

   logic          en;
   logic          in_valid, in_fire, in_user, in_last;
   logic [DW-1:0] in_data;

   assign en      = m_tready_i | ~m_tvalid_o;
   assign in_fire = in_valid & en;

`ifdef CONV_MAC_SKID_EN
   logic [DW+1:0] skid_mem [2];
   logic          skid_wp, skid_rp, skid_rdy, push;
   logic [1:0]    skid_cnt, skid_cnt_nx;

   assign push        = s_tvalid_i & skid_rdy;
   assign skid_cnt_nx = skid_cnt + 2'(push) - 2'(in_fire);

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         skid_wp  <= 1'b0;
         skid_rp  <= 1'b0;
         skid_cnt <= 2'd0;
         skid_rdy <= 1'b1;
      end else begin
         if (push)    skid_wp <= ~skid_wp;
         if (in_fire) skid_rp <= ~skid_rp;
         skid_cnt <= skid_cnt_nx;
         skid_rdy <= (skid_cnt_nx != 2'd2);
      end
   end

   always_ff @(posedge clk) begin
      if (push) skid_mem[skid_wp] <= {s_tuser_i, s_tlast_i, s_tdata_i};
   end

   // No bypass: every beat spends one cycle in the skid, keeping latency fixed.
   assign in_valid                     = (skid_cnt != 2'd0);
   assign {in_user, in_last, in_data}  = skid_mem[skid_rp];
   assign s_tready_o                   = skid_rdy;
`else
   assign in_valid   = s_tvalid_i;
   assign in_user    = s_tuser_i;
   assign in_last    = s_tlast_i;
   assign in_data    = s_tdata_i;
   assign s_tready_o = en;
`endif

   logic signed [COEF_W-1:0] active   [N];
   logic signed [COEF_W-1:0] shadow   [N];
   logic signed [COEF_W-1:0] coef_sel [N];
   logic                     pending, swap;

   // A frame-start beat that triggers the swap already multiplies with the shadow bank.
   assign swap           = in_fire & in_user & pending;
   assign coef_pending_o = pending;

   always_comb begin
      for (int k = 0; k < N; k++) coef_sel[k] = swap ? shadow[k] : active[k];
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int k = 0; k < N; k++) begin
            active[k] <= (k == 12) ? UNITY : '0;
            shadow[k] <= (k == 12) ? UNITY : '0;
         end
         pending <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (coef_wr_i && coef_addr_i == 5'(k)) shadow[k] <= coef_data_i;
            if (swap) active[k] <= shadow[k];
         end
         if (coef_commit_i) pending <= 1'b1;
         else if (swap)     pending <= 1'b0;
      end
   end

   logic [3:1]           vld_pipe;
   logic [2:1]           user_pipe, last_pipe;
   logic signed [PW-1:0] prod   [N];
   logic signed [RW-1:0] row    [5];
   logic signed [RW-1:0] row_nx [5];
   logic signed [SW-1:0] total, rounded, shifted;
   logic [PIXEL_W-1:0]   sat;

   always_comb begin
      for (int r = 0; r < 5; r++) begin
         row_nx[r] = '0;
         for (int c = 0; c < 5; c++) row_nx[r] = row_nx[r] + RW'(prod[r*5+c]);
      end
      total = '0;
      for (int r = 0; r < 5; r++) total = total + SW'(row[r]);
      rounded = total + RND;
      shifted = rounded >>> SHIFT;
      if (shifted[SW-1])       sat = '0;
      else if (shifted > PMAX) sat = '1;
      else                     sat = shifted[PIXEL_W-1:0];
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) vld_pipe <= '0;
      else if (en) vld_pipe <= {vld_pipe[2:1], in_valid};
   end

   // Payload registers need no reset; validity is carried by vld_pipe alone.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int k = 0; k < N; k++)
            prod[k] <= PW'($signed({1'b0, in_data[k*PIXEL_W +: PIXEL_W]})) * PW'(coef_sel[k]);
         for (int r = 0; r < 5; r++) row[r] <= row_nx[r];
         user_pipe <= {user_pipe[1], in_user};
         last_pipe <= {last_pipe[1], in_last};
         m_tdata_o <= sat;
         m_tuser_o <= user_pipe[2];
         m_tlast_o <= last_pipe[2];
      end
   end

   assign m_tvalid_o = vld_pipe[3];

endmodule
